// File: rtl/if_id_stage_if.sv
// rtl/if_id_stage_if.sv - fetch/decode handshake and decode-field bundle for if_id_stage
interface if_id_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc4;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [4:0]  out_shamt;
    logic [5:0]  out_funct;
    logic [15:0] out_imm16;
    logic        out_sign_extend;

    modport slave (
        input  in_valid, in_instr, in_pc4, stall, flush,
        output in_ready, out_valid, out_instr, out_pc4, out_opcode, out_rs, out_rt,
               out_rd, out_shamt, out_funct, out_imm16, out_sign_extend
    );

    modport master (
        output in_valid, in_instr, in_pc4, stall, flush,
        input  in_ready, out_valid, out_instr, out_pc4, out_opcode, out_rs, out_rt,
               out_rd, out_shamt, out_funct, out_imm16, out_sign_extend
    );
endinterface

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID 2-entry skid buffer with stall/flush and instruction field decode
module if_id_stage (
    input  logic          clk,
    input  logic          rst_n,
    if_id_stage_if.slave  bus
);
    logic [1:0]  count_q, count_d;
    logic [31:0] h_instr_q, h_instr_d;
    logic [31:0] h_pc4_q, h_pc4_d;
    logic [31:0] t_instr_q, t_instr_d;
    logic [31:0] t_pc4_q, t_pc4_d;
    logic        ready_q;
    logic        accept;
    logic        consume;
    logic        head_valid;
    logic [31:0] instr;

    assign head_valid = (count_q != 2'd0);
    assign accept     = bus.in_valid && ready_q && !bus.flush;
    assign consume    = head_valid && !bus.stall && !bus.flush;

    always_comb begin
        count_d   = count_q;
        h_instr_d = h_instr_q;
        h_pc4_d   = h_pc4_q;
        t_instr_d = t_instr_q;
        t_pc4_d   = t_pc4_q;
        if (bus.flush) begin
            count_d   = 2'd0;
            h_instr_d = 32'h0;
            h_pc4_d   = 32'h0;
            t_instr_d = 32'h0;
            t_pc4_d   = 32'h0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (accept) begin
                        h_instr_d = bus.in_instr;
                        h_pc4_d   = bus.in_pc4;
                        count_d   = 2'd1;
                    end
                end
                2'd1: begin
                    if (accept && consume) begin
                        h_instr_d = bus.in_instr;
                        h_pc4_d   = bus.in_pc4;
                    end else if (accept) begin
                        t_instr_d = bus.in_instr;
                        t_pc4_d   = bus.in_pc4;
                        count_d   = 2'd2;
                    end else if (consume) begin
                        h_instr_d = 32'h0;
                        h_pc4_d   = 32'h0;
                        count_d   = 2'd0;
                    end
                end
                default: begin
                    // Full: ready was low last cycle, so only a drain can happen here.
                    if (consume) begin
                        h_instr_d = t_instr_q;
                        h_pc4_d   = t_pc4_q;
                        t_instr_d = 32'h0;
                        t_pc4_d   = 32'h0;
                        count_d   = 2'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= 2'd0;
            h_instr_q <= 32'h0;
            h_pc4_q   <= 32'h0;
            t_instr_q <= 32'h0;
            t_pc4_q   <= 32'h0;
            ready_q   <= 1'b1;
        end else begin
            count_q   <= count_d;
            h_instr_q <= h_instr_d;
            h_pc4_q   <= h_pc4_d;
            t_instr_q <= t_instr_d;
            t_pc4_q   <= t_pc4_d;
            ready_q   <= (count_d < 2'd2);
        end
    end

    assign instr               = head_valid ? h_instr_q : 32'h0;
    assign bus.in_ready        = ready_q;
    assign bus.out_valid       = head_valid;
    assign bus.out_instr       = instr;
    assign bus.out_pc4         = head_valid ? h_pc4_q : 32'h0;
    assign bus.out_opcode      = instr[31:26];
    assign bus.out_rs          = instr[25:21];
    assign bus.out_rt          = instr[20:16];
    assign bus.out_rd          = instr[15:11];
    assign bus.out_shamt       = instr[10:6];
    assign bus.out_funct       = instr[5:0];
    assign bus.out_imm16       = instr[15:0];
    // andi/ori/xori/lui (0x0C..0x0F) take a zero-extended immediate.
    assign bus.out_sign_extend = (instr[31:28] != 4'b0011);
endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - self-checking bench for if_id_stage
module tb_if_id_stage;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [63:0] model_q[$];
    logic        m_ready;

    if_id_stage_if bus ();

    if_id_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_sext(input logic [31:0] ins);
        logic [5:0] op;
        op = ins[31:26];
        return !(op == 6'h0C || op == 6'h0D || op == 6'h0E || op == 6'h0F);
    endfunction

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic st, input logic fl);
        logic acc;
        logic cons;
        logic [31:0] ei;
        logic [31:0] ep;
        @(negedge clk);
        bus.in_valid = v;
        bus.in_instr = ins;
        bus.in_pc4   = pc;
        bus.stall    = st;
        bus.flush    = fl;
        acc  = v && m_ready && !fl;
        cons = (model_q.size() != 0) && !st && !fl;
        @(posedge clk);
        if (fl) model_q.delete();
        else begin
            if (cons) void'(model_q.pop_front());
            if (acc) model_q.push_back({ins, pc});
        end
        m_ready = (model_q.size() < 2);
        #1;
        ei = (model_q.size() != 0) ? model_q[0][63:32] : 32'h0;
        ep = (model_q.size() != 0) ? model_q[0][31:0]  : 32'h0;
        check("out_valid", {31'h0, bus.out_valid}, {31'h0, model_q.size() != 0});
        check("in_ready", {31'h0, bus.in_ready}, {31'h0, m_ready});
        check("out_instr", bus.out_instr, ei);
        check("out_pc4", bus.out_pc4, ep);
        check("out_opcode", {26'h0, bus.out_opcode}, {26'h0, ei[31:26]});
        check("out_rt", {27'h0, bus.out_rt}, {27'h0, ei[20:16]});
        check("out_imm16", {16'h0, bus.out_imm16}, {16'h0, ei[15:0]});
        check("out_sext", {31'h0, bus.out_sign_extend}, {31'h0, exp_sext(ei)});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_ready  = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_instr = 32'h0;
        bus.in_pc4   = 32'h0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        rst_n = 1'b0;
        #12;
        check("rst_valid", {31'h0, bus.out_valid}, 32'h0);
        check("rst_ready", {31'h0, bus.in_ready}, 32'h1);
        check("rst_instr", bus.out_instr, 32'h0);
        check("rst_pc4", bus.out_pc4, 32'h0);
        check("rst_imm16", {16'h0, bus.out_imm16}, 32'h0);
        check("rst_sext", {31'h0, bus.out_sign_extend}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Two-instruction stream, no stall
        step(1'b1, 32'h2008_0005, 32'h04, 1'b0, 1'b0);
        check("addi_imm", {16'h0, bus.out_imm16}, 32'h0005);
        check("addi_sext", {31'h0, bus.out_sign_extend}, 32'h1);
        check("addi_rt", {27'h0, bus.out_rt}, 32'h8);
        step(1'b1, 32'h3409_FFFF, 32'h08, 1'b0, 1'b0);
        check("ori_imm", {16'h0, bus.out_imm16}, 32'hFFFF);
        check("ori_sext", {31'h0, bus.out_sign_extend}, 32'h0);
        check("ori_pc4", bus.out_pc4, 32'h08);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("drain_valid", {31'h0, bus.out_valid}, 32'h0);

        // Stall absorbs one extra instruction, then order A, B, C
        step(1'b1, 32'hAAAA_0001, 32'h10, 1'b0, 1'b0);
        step(1'b1, 32'hBBBB_0002, 32'h14, 1'b1, 1'b0);
        check("stall_headA", bus.out_instr, 32'hAAAA_0001);
        check("stall_ready0", {31'h0, bus.in_ready}, 32'h0);
        step(1'b1, 32'hCCCC_0003, 32'h18, 1'b1, 1'b0);
        step(1'b1, 32'hCCCC_0003, 32'h18, 1'b1, 1'b0);
        check("stall_holdA", bus.out_instr, 32'hAAAA_0001);
        step(1'b1, 32'hCCCC_0003, 32'h18, 1'b0, 1'b0);
        check("order_B", bus.out_instr, 32'hBBBB_0002);
        step(1'b1, 32'hCCCC_0003, 32'h18, 1'b0, 1'b0);
        check("order_C", bus.out_instr, 32'hCCCC_0003);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Flush with full buffer, stall and incoming instruction
        step(1'b1, 32'h1111_0001, 32'h20, 1'b1, 1'b0);
        step(1'b1, 32'h2222_0002, 32'h24, 1'b1, 1'b0);
        step(1'b1, 32'hDDDD_0004, 32'h28, 1'b1, 1'b1);
        check("flush_valid", {31'h0, bus.out_valid}, 32'h0);
        check("flush_instr", bus.out_instr, 32'h0);
        check("flush_ready", {31'h0, bus.in_ready}, 32'h1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("flush_dropped", {31'h0, bus.out_valid}, 32'h0);

        // Opcode sweep
        for (int op = 0; op < 64; op++) begin
            step(1'b1, {op[5:0], 26'h0123456}, 32'h100 + op * 4, 1'b0, 1'b0);
        end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Asynchronous reset with a full buffer
        step(1'b1, 32'h3C01_1234, 32'h40, 1'b1, 1'b0);
        step(1'b1, 32'h3C02_5678, 32'h44, 1'b1, 1'b0);
        check("full_ready", {31'h0, bus.in_ready}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'h0, bus.out_valid}, 32'h0);
        check("arst_ready", {31'h0, bus.in_ready}, 32'h1);
        check("arst_instr", bus.out_instr, 32'h0);
        check("arst_sext", {31'h0, bus.out_sign_extend}, 32'h1);
        model_q.delete();
        m_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h2010_0007, 32'h50, 1'b0, 1'b0);
        check("post_rst_instr", bus.out_instr, 32'h2010_0007);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Random handshake against the FIFO model
        for (int i = 0; i < 300; i++) begin
            step(($urandom % 4) != 0, $urandom, $urandom,
                 ($urandom % 3) == 0, ($urandom % 16) == 0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
